// File: rtl/spi_shader_loader_if.sv
// SPI pin and shader-memory port bundle for spi_shader_loader.
// slave: the loader itself; master: the SPI host / memory side.
interface spi_shader_loader_if #(
  parameter int INSTR_W = 8,
  parameter int DEPTH   = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic               spi_sclk_i;
  logic               spi_mosi_i;
  logic               spi_cs_i;
  logic               spi_miso_o;
  logic               mem_we_o;
  logic [ADDR_W-1:0]  mem_addr_o;
  logic [INSTR_W-1:0] mem_wdata_o;
  logic [INSTR_W-1:0] mem_rdata_i;
  logic               loading_o;
  logic               done_o;

  modport slave (
    input  spi_sclk_i, spi_mosi_i, spi_cs_i, mem_rdata_i,
    output spi_miso_o, mem_we_o, mem_addr_o, mem_wdata_o, loading_o, done_o
  );

  modport master (
    output spi_sclk_i, spi_mosi_i, spi_cs_i, mem_rdata_i,
    input  spi_miso_o, mem_we_o, mem_addr_o, mem_wdata_o, loading_o, done_o
  );
endinterface

// File: rtl/spi_shader_loader.sv
// SPI mode-0 target that writes shader words into instruction memory
// (command 0x00) or streams them back on MISO (command 0x01).
module spi_shader_loader #(
  parameter int INSTR_W     = 8,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               rst_n,
  spi_shader_loader_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2((INSTR_W > 8) ? INSTR_W : 8);
  localparam int WSH_W  = INSTR_W - 1;
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(INSTR_W - 1);

  typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, IGNORE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, mosi_s, cs_s;
  logic                   rise, fall, cs_rise, cs_fall;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [6:0]         cmd_sh;
  logic [WSH_W-1:0]   wsh;
  logic [INSTR_W-1:0] rsh, rsh_next;
  logic [ADDR_W-1:0]  addr;
  logic [INSTR_W-1:0] wdata;
  logic               we, miso, loading, done, wrote;

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign rise    = sclk_s & ~sclk_d;
  assign fall    = ~sclk_s & sclk_d;
  assign cs_rise = cs_s & ~cs_d;
  assign cs_fall = ~cs_s & cs_d;

  assign bus.spi_miso_o  = miso;
  assign bus.mem_we_o    = we;
  assign bus.mem_addr_o  = addr;
  assign bus.mem_wdata_o = wdata;
  assign bus.loading_o   = loading;
  assign bus.done_o      = done;

  // Synchronise the asynchronous SPI pins and keep one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_i};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  // Read shifter: first bit of a word reloads from memory, later bits shift left.
  always_comb begin
    rsh_next = rsh << 1;
    if (cnt == '0) rsh_next = bus.mem_rdata_i;
  end

  // Transaction FSM with all outputs registered; CS edges take priority over SCLK edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      cmd_sh  <= '0;
      wsh     <= '0;
      rsh     <= '0;
      addr    <= '0;
      wdata   <= '0;
      we      <= 1'b0;
      miso    <= 1'b0;
      loading <= 1'b0;
      done    <= 1'b0;
      wrote   <= 1'b0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      // address advances the cycle after the write strobe, so the write uses the old value
      if (we) addr <= addr + ADDR_W'(1);
      if (cs_rise) begin
        state   <= IDLE;
        cnt     <= '0;
        miso    <= 1'b0;
        loading <= 1'b0;
        done    <= wrote;
        wrote   <= 1'b0;
      end else if (cs_fall) begin
        state   <= CMD;
        cnt     <= '0;
        addr    <= '0;
        miso    <= 1'b0;
        loading <= 1'b0;
        wrote   <= 1'b0;
      end else begin
        case (state)
          CMD: begin
            if (rise) begin
              cmd_sh <= 7'({cmd_sh, mosi_s});
              if (cnt == CMD_LAST) begin
                cnt <= '0;
                case ({cmd_sh, mosi_s})
                  8'h00: begin
                    state   <= WRITE;
                    loading <= 1'b1;
                  end
                  8'h01:   state <= READ;
                  default: state <= IGNORE;
                endcase
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          WRITE: begin
            if (rise) begin
              wsh <= WSH_W'({wsh, mosi_s});
              if (cnt == WORD_LAST) begin
                cnt   <= '0;
                wdata <= {wsh, mosi_s};
                we    <= 1'b1;
                wrote <= 1'b1;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          READ: begin
            if (fall) begin
              rsh  <= rsh_next;
              miso <= rsh_next[INSTR_W-1];
            end else if (rise) begin
              if (cnt == WORD_LAST) begin
                cnt  <= '0;
                addr <= addr + ADDR_W'(1);
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_shader_loader.sv
// Directed + randomized bench for spi_shader_loader with a memory-content reference model.
module tb_spi_shader_loader;
  localparam int INSTR_W = 8;
  localparam int DEPTH   = 16;
  localparam int HALF    = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_shader_loader_if #(.INSTR_W(INSTR_W), .DEPTH(DEPTH)) bus ();

  spi_shader_loader #(.INSTR_W(INSTR_W), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem [DEPTH];
  logic [7:0] model_mem [DEPTH];
  logic [7:0] stim [32];
  int         wr_addr_q [$];
  int         wr_data_q [$];
  int         we_cnt = 0;
  int         done_cnt = 0;
  int         load_cnt = 0;
  int         checks = 0;
  int         failures = 0;

  assign bus.mem_rdata_i = mem[bus.mem_addr_o];

  // Memory behind the loader plus event counters sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.mem_we_o) begin
      mem[bus.mem_addr_o] <= bus.mem_wdata_o;
      wr_addr_q.push_back(int'(bus.mem_addr_o));
      wr_data_q.push_back(int'(bus.mem_wdata_o));
      we_cnt <= we_cnt + 1;
    end
    if (bus.done_o)    done_cnt <= done_cnt + 1;
    if (bus.loading_o) load_cnt <= load_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer_bits(input logic [7:0] w, input int nbits, output logic [7:0] rd);
    rd = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.spi_mosi_i = w[7-i];
      wait_clks(HALF);
      rd = {rd[6:0], bus.spi_miso_o};
      bus.spi_sclk_i = 1'b1;
      wait_clks(HALF);
      bus.spi_sclk_i = 1'b0;
    end
  endtask

  task automatic cs_begin(input logic [7:0] cmd);
    logic [7:0] rd;
    bus.spi_cs_i = 1'b0;
    wait_clks(HALF);
    xfer_bits(cmd, 8, rd);
  endtask

  task automatic cs_end();
    wait_clks(HALF);
    bus.spi_cs_i = 1'b1;
    wait_clks(2 * HALF);
  endtask

  // Write stim[0..n-1]; model: word i lands at address i mod DEPTH.
  task automatic write_txn(input int n, input bit chk_load);
    logic [7:0] rd;
    cs_begin(8'h00);
    for (int i = 0; i < n; i++) begin
      xfer_bits(stim[i], 8, rd);
      model_mem[i % DEPTH] = stim[i];
      if (chk_load) check($sformatf("loading_w%0d", i), 32'(bus.loading_o), 32'd1);
    end
    cs_end();
  endtask

  task automatic check_log(input int base, input int n);
    check("we_count", 32'(wr_addr_q.size() - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (base + i < wr_addr_q.size()) begin
        check($sformatf("wr_addr%0d", i), 32'(wr_addr_q[base+i]), 32'(i % DEPTH));
        check($sformatf("wr_data%0d", i), 32'(wr_data_q[base+i]), 32'(stim[i]));
      end
    end
  endtask

  task automatic read_txn(input int n);
    logic [7:0] rd;
    cs_begin(8'h01);
    for (int i = 0; i < n; i++) begin
      xfer_bits(8'($urandom), 8, rd);
      check($sformatf("rd%0d", i), 32'(rd), 32'(model_mem[i % DEPTH]));
    end
    cs_end();
  endtask

  initial begin
    int base, d0, l0, n;
    logic [7:0] rd;
    bus.spi_sclk_i = 1'b0;
    bus.spi_mosi_i = 1'b0;
    bus.spi_cs_i   = 1'b1;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

    // reset state
    wait_clks(5);
    check("rst_we",      32'(bus.mem_we_o),    32'd0);
    check("rst_addr",    32'(bus.mem_addr_o),  32'd0);
    check("rst_wdata",   32'(bus.mem_wdata_o), 32'd0);
    check("rst_miso",    32'(bus.spi_miso_o),  32'd0);
    check("rst_loading", 32'(bus.loading_o),   32'd0);
    check("rst_done",    32'(bus.done_o),      32'd0);
    rst_n = 1'b1;
    wait_clks(2 * HALF);

    // 1: write 16 words 0x10..0x1F
    for (int i = 0; i < 16; i++) stim[i] = 8'h10 + 8'(i);
    base = wr_addr_q.size(); d0 = done_cnt;
    write_txn(16, 1'b1);
    check_log(base, 16);
    check("t1_done", 32'(done_cnt - d0), 32'd1);
    check("t1_loading_after", 32'(bus.loading_o), 32'd0);

    // 2: preload 0xA0+i, then read 16 words back
    for (int i = 0; i < 16; i++) stim[i] = 8'hA0 + 8'(i);
    write_txn(16, 1'b0);
    base = wr_addr_q.size(); d0 = done_cnt; l0 = load_cnt;
    read_txn(16);
    check("t2_no_we", 32'(wr_addr_q.size() - base), 32'd0);
    check("t2_loading", 32'(load_cnt - l0), 32'd0);
    check("t2_done", 32'(done_cnt - d0), 32'd0);
    check("t2_miso_idle", 32'(bus.spi_miso_o), 32'd0);

    // 3: 17 words, the 17th wraps to address 0
    for (int i = 0; i < 16; i++) stim[i] = 8'($urandom);
    stim[16] = 8'h55;
    base = wr_addr_q.size(); d0 = done_cnt;
    write_txn(17, 1'b0);
    check_log(base, 17);
    check("t3_done", 32'(done_cnt - d0), 32'd1);

    // 4: two words then CS high 3 bits into the third
    stim[0] = 8'($urandom); stim[1] = 8'($urandom);
    base = wr_addr_q.size(); d0 = done_cnt;
    cs_begin(8'h00);
    xfer_bits(stim[0], 8, rd);
    xfer_bits(stim[1], 8, rd);
    xfer_bits(8'($urandom), 3, rd);
    cs_end();
    model_mem[0] = stim[0]; model_mem[1] = stim[1];
    check_log(base, 2);
    check("t4_done", 32'(done_cnt - d0), 32'd1);
    check("t4_loading", 32'(bus.loading_o), 32'd0);

    // 5: unknown command 0x7E followed by 24 clocks
    base = wr_addr_q.size(); d0 = done_cnt; l0 = load_cnt;
    cs_begin(8'h7E);
    for (int i = 0; i < 3; i++) begin
      xfer_bits(8'($urandom), 8, rd);
      check($sformatf("t5_miso%0d", i), 32'(rd), 32'd0);
    end
    cs_end();
    check("t5_no_we", 32'(wr_addr_q.size() - base), 32'd0);
    check("t5_loading", 32'(load_cnt - l0), 32'd0);
    check("t5_done", 32'(done_cnt - d0), 32'd0);

    // 6: reset in the middle of the second write word
    stim[0] = 8'($urandom);
    base = wr_addr_q.size(); d0 = done_cnt;
    cs_begin(8'h00);
    xfer_bits(stim[0], 8, rd);
    model_mem[0] = stim[0];
    xfer_bits(8'hC3, 4, rd);
    rst_n = 1'b0;
    #1;
    check("t6_we",      32'(bus.mem_we_o),    32'd0);
    check("t6_addr",    32'(bus.mem_addr_o),  32'd0);
    check("t6_wdata",   32'(bus.mem_wdata_o), 32'd0);
    check("t6_loading", 32'(bus.loading_o),   32'd0);
    check("t6_miso",    32'(bus.spi_miso_o),  32'd0);
    check("t6_done",    32'(bus.done_o),      32'd0);
    wait_clks(3);
    rst_n = 1'b1;
    xfer_bits(8'h3C, 4, rd);
    cs_end();
    check("t6_one_we", 32'(wr_addr_q.size() - base), 32'd1);
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);
    stim[0] = 8'($urandom);
    base = wr_addr_q.size();
    write_txn(1, 1'b1);
    check_log(base, 1);

    // random write/read-back against the memory model
    for (int r = 0; r < 2; r++) begin
      n = int'($urandom_range(1, 20));
      for (int i = 0; i < n; i++) stim[i] = 8'($urandom);
      base = wr_addr_q.size();
      write_txn(n, 1'b0);
      check_log(base, n);
      read_txn(n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
